// File: rtl/spi_pkg.sv
// Shared constants and types for the programmable SPI master.
package spi_pkg;

  // Avalon register addresses
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DIV    = 3'd1;
  localparam logic [2:0] ADDR_TXDATA = 3'd2;
  localparam logic [2:0] ADDR_RXDATA = 3'd3;
  localparam logic [2:0] ADDR_SS     = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // CTRL bit positions
  localparam int unsigned CTRL_CPOL      = 0;
  localparam int unsigned CTRL_CPHA      = 1;
  localparam int unsigned CTRL_LSB_FIRST = 2;
  localparam int unsigned CTRL_IRQ_EN    = 3;
  localparam int unsigned CTRL_W         = 4;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: divides clk by DIV+1 into ticks; while shifting, each
// tick is an sclk edge, classified as leading (away from CPOL) or trailing.
module spi_clk_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_i,
  input  logic                 shift_i,
  input  logic                 cpol_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o,
  output logic                 lead_o,
  output logic                 trail_o,
  output logic                 sclk_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sclk_q, sclk_d;

  // Divider count, edge strobes and next sclk level
  always_comb begin
    tick_o  = en_i && (cnt_q == div_i);
    lead_o  = tick_o && shift_i && (sclk_q == cpol_i);
    trail_o = tick_o && shift_i && (sclk_q != cpol_i);

    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    sclk_d = sclk_q;
    if (!en_i) begin
      sclk_d = cpol_i;
    end else if (lead_o || trail_o) begin
      sclk_d = ~sclk_q;
    end
  end

  // Divider and sclk registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_cfg.sv
// Avalon-MM programmable SPI master: configurable width, CPOL/CPHA, bit order,
// runtime divider, busy/done/error status and level interrupt.
module spi_master_cfg #(
  parameter int unsigned NUMBER_SLAVES = 1,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DIV_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic [NUMBER_SLAVES-1:0] ss_n,
  output logic                     irq,
  input  logic [2:0]               avs_address,
  input  logic                     avs_read,
  output logic [31:0]              avs_readdata,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata
);

  import spi_pkg::*;

  localparam int unsigned EDGES = 2 * DATA_WIDTH;
  localparam int unsigned EW    = $clog2(EDGES);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

  spi_state_e                state_q, state_d;
  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [DATA_WIDTH-1:0]     tx_q, tx_d;
  logic [DATA_WIDTH-1:0]     rx_q, rx_d;
  logic [DATA_WIDTH-1:0]     tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]     rx_sh_q, rx_sh_d;
  logic [4:0]                ss_idx_q, ss_idx_d;
  logic [NUMBER_SLAVES-1:0]  ss_n_q, ss_n_d;
  logic [EW-1:0]             ec_q, ec_d;
  logic                      mosi_q, mosi_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [31:0]               rdata_q, rdata_d;

  logic wr_en, busy, ss_wr, ss_bad, start;
  logic tick, lead, trail, sclk_int;
  logic cpha, lsb;
  logic drive, sample;

  // Access decode; a read in the same cycle drops the write
  always_comb begin
    wr_en  = avs_write && !avs_read;
    busy   = (state_q != IDLE);
    ss_wr  = wr_en && (avs_address == ADDR_SS) && !busy;
    ss_bad = ss_wr && (avs_writedata >= 32'(NUMBER_SLAVES));
    start  = ss_wr && !ss_bad;
    cpha   = ctrl_q[CTRL_CPHA];
    lsb    = ctrl_q[CTRL_LSB_FIRST];
  end

  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (busy),
    .shift_i (state_q == SHIFT),
    .cpol_i  (ctrl_d[CTRL_CPOL]),
    .div_i   (div_q),
    .tick_o  (tick),
    .lead_o  (lead),
    .trail_o (trail),
    .sclk_o  (sclk_int)
  );

  // Register file, transfer sequencer and read mux
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    ss_idx_d = ss_idx_q;
    ss_n_d   = ss_n_q;
    ec_d     = ec_q;
    mosi_d   = mosi_q;
    done_d   = done_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    drive    = 1'b0;
    sample   = 1'b0;

    // Configuration writes are frozen while a transfer is in flight
    if (wr_en && !busy) begin
      case (avs_address)
        ADDR_CTRL:   ctrl_d = avs_writedata[CTRL_W-1:0];
        ADDR_DIV:    div_d  = avs_writedata[DIV_WIDTH-1:0];
        ADDR_TXDATA: tx_d   = avs_writedata[DATA_WIDTH-1:0];
        default:     ;
      endcase
    end

    // Status clears first so that any set below takes priority
    if (wr_en && (avs_address == ADDR_STATUS)) begin
      if (avs_writedata[STAT_DONE]) done_d = 1'b0;
      if (avs_writedata[STAT_ERR])  err_d  = 1'b0;
    end
    if (avs_read && (avs_address == ADDR_RXDATA)) begin
      done_d = 1'b0;
    end
    if (ss_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          ss_idx_d = avs_writedata[4:0];
          ss_n_d   = ~(NUMBER_SLAVES'(1) << avs_writedata[4:0]);
          done_d   = 1'b0;
          tx_sh_d  = tx_q;
          rx_sh_d  = '0;
          ec_d     = '0;
          if (!cpha) begin
            mosi_d = lsb ? tx_q[0] : tx_q[DATA_WIDTH-1];
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // CPHA=0 has its first bit already on mosi, so the last trailing edge drives nothing
        drive  = cpha ? lead : (trail && (ec_q != LAST_EDGE));
        sample = cpha ? trail : lead;
        if (drive) begin
          if (cpha) begin
            mosi_d = lsb ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
          end else begin
            mosi_d = lsb ? tx_sh_q[1] : tx_sh_q[DATA_WIDTH-2];
          end
          tx_sh_d = lsb ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        end
        if (sample) begin
          rx_sh_d = lsb ? {miso, rx_sh_q[DATA_WIDTH-1:1]}
                        : {rx_sh_q[DATA_WIDTH-2:0], miso};
        end
        if (lead || trail) begin
          if (ec_q == LAST_EDGE) begin
            ec_d    = '0;
            state_d = HOLD;
          end else begin
            ec_d = ec_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          ss_n_d  = '1;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_CTRL:   rdata_d[CTRL_W-1:0]     = ctrl_q;
        ADDR_DIV:    rdata_d[DIV_WIDTH-1:0]  = div_q;
        ADDR_TXDATA: rdata_d[DATA_WIDTH-1:0] = tx_q;
        ADDR_RXDATA: rdata_d[DATA_WIDTH-1:0] = rx_q;
        ADDR_SS:     rdata_d[4:0]            = ss_idx_q;
        ADDR_STATUS: rdata_d[2:0]            = {err_q, done_q, busy};
        default:     ;
      endcase
    end
  end

  // State and register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      div_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      ss_idx_q <= '0;
      ss_n_q   <= '1;
      ec_q     <= '0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      ss_idx_q <= ss_idx_d;
      ss_n_q   <= ss_n_d;
      ec_q     <= ec_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sclk         = sclk_int;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;
  assign irq          = done_q && ctrl_q[CTRL_IRQ_EN];
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed self-checking bench for spi_master_cfg (2 slaves, 8-bit words).
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int unsigned NS  = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned DVW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sclk, mosi, miso, irq;
  logic [NS-1:0] ss_n;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;

  int n_checks = 0;
  int n_err    = 0;

  // bus-side slave model and monitor state
  logic       loop_en = 1'b1;
  logic       slave_bit = 1'b0;
  logic       tb_cpol = 1'b0, tb_cpha = 1'b0, tb_lsb = 1'b0;
  logic [7:0] s_word = '0;
  logic [7:0] cap = '0;
  int         low_cnt = 0, low1_cnt = 0, edge_cnt = 0, xfer_cnt = 0, lead_cnt = 0;
  logic       sclk_prev = 1'b0, ss0_prev = 1'b1;

  always #5 clk = ~clk;

  spi_master_cfg #(
    .NUMBER_SLAVES (NS),
    .DATA_WIDTH    (DW),
    .DIV_WIDTH     (DVW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .ss_n          (ss_n),
    .irq           (irq),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata)
  );

  always_comb miso = loop_en ? mosi : slave_bit;

  always @(negedge clk) begin
    logic lead;
    if (!ss_n[0]) low_cnt++;
    if (!ss_n[1]) low1_cnt++;
    if (!ss_n[0] && ss0_prev) begin
      xfer_cnt++;
      lead_cnt  = 0;
      slave_bit = 1'b0;
    end
    if (!ss_n[0] && (sclk != sclk_prev)) begin
      edge_cnt++;
      lead = (sclk != tb_cpol);
      if (lead) begin
        lead_cnt++;
        if (tb_cpha && lead_cnt >= 1 && lead_cnt <= 8)
          slave_bit = tb_lsb ? s_word[lead_cnt-1] : s_word[8-lead_cnt];
      end
      if (lead != tb_cpha)
        cap = tb_lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
    end
    sclk_prev = sclk;
    ss0_prev  = ss_n[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] d;
    logic        idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      avs_rd(ADDR_STATUS, d);
      if (!d[STAT_BUSY]) idle = 1'b1;
    end
    chk(nm, {31'd0, idle}, 32'd1);
  endtask

  task automatic clr_mon();
    low_cnt  = 0;
    low1_cnt = 0;
    edge_cnt = 0;
    xfer_cnt = 0;
    cap      = '0;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        sclk;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b0, ADDR_CTRL,   32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, ADDR_DIV,    32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, ADDR_TXDATA, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, ADDR_RXDATA, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, ADDR_SS,     32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, ADDR_STATUS, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 3'd6,        32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 3'd7,        32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, ADDR_CTRL,   32'hFFFF_FFF5, 1'b1};
    vecs[9]  = '{1'b0, ADDR_CTRL,   32'h0000_0005, 1'b1};
    vecs[10] = '{1'b1, ADDR_DIV,    32'h0001_2345, 1'b1};
    vecs[11] = '{1'b0, ADDR_DIV,    32'h0000_2345, 1'b1};
    vecs[12] = '{1'b1, ADDR_TXDATA, 32'hDEAD_BE5A, 1'b1};
    vecs[13] = '{1'b0, ADDR_TXDATA, 32'h0000_005A, 1'b1};
    vecs[14] = '{1'b1, ADDR_RXDATA, 32'h0000_0077, 1'b1};
    vecs[15] = '{1'b0, ADDR_RXDATA, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, ADDR_CTRL,   32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, ADDR_CTRL,   32'h0000_0000, 1'b0};
    vecs[18] = '{1'b1, ADDR_STATUS, 32'h0000_0007, 1'b0};
    vecs[19] = '{1'b0, ADDR_STATUS, 32'h0000_0000, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_ss_n", {30'd0, ss_n}, 32'h3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset_n = 1'b1;

    // register access table
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) begin
        avs_wr(vecs[i].addr, vecs[i].data);
      end else begin
        avs_rd(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].data);
      end
      chk($sformatf("vec%0d_sclk", i), {31'd0, sclk}, {31'd0, vecs[i].sclk});
    end

    // mode 0, MSB first, DIV=1, loopback of 0xA5
    tb_cpol = 0; tb_cpha = 0; tb_lsb = 0; loop_en = 1;
    avs_wr(ADDR_CTRL, 32'h0);
    avs_wr(ADDR_DIV, 32'h1);
    avs_wr(ADDR_TXDATA, 32'hA5);
    clr_mon();
    avs_wr(ADDR_SS, 32'h0);
    chk("m0_ss_start", {30'd0, ss_n}, 32'h2);
    chk("m0_first_bit", {31'd0, mosi}, 32'd1);
    wait_idle("m0_timeout");
    chk("m0_ss_low", low_cnt, 32'd36);
    chk("m0_edges", edge_cnt, 32'd16);
    chk("m0_mosi_word", {24'd0, cap}, 32'hA5);
    avs_rd(ADDR_STATUS, rd);
    chk("m0_status", rd, 32'h2);
    avs_rd(ADDR_RXDATA, rd);
    chk("m0_rx", rd, 32'hA5);
    avs_rd(ADDR_STATUS, rd);
    chk("m0_done_rdclr", rd, 32'h0);

    // mode 3, LSB first, DIV=3, slave sends 0x3C, master sends 0x96
    tb_cpol = 1; tb_cpha = 1; tb_lsb = 1; loop_en = 0; s_word = 8'h3C;
    avs_wr(ADDR_CTRL, 32'h7);
    chk("m3_idle_sclk", {31'd0, sclk}, 32'd1);
    avs_wr(ADDR_DIV, 32'h3);
    avs_wr(ADDR_TXDATA, 32'h96);
    clr_mon();
    avs_wr(ADDR_SS, 32'h0);
    chk("m3_ss_start", {30'd0, ss_n}, 32'h2);
    wait_idle("m3_timeout");
    chk("m3_ss_low", low_cnt, 32'd72);
    chk("m3_edges", edge_cnt, 32'd16);
    chk("m3_mosi_lsb", {24'd0, cap}, 32'h96);
    chk("m3_end_sclk", {31'd0, sclk}, 32'd1);
    avs_rd(ADDR_RXDATA, rd);
    chk("m3_rx", rd, 32'h3C);

    // writes while busy are ignored
    tb_cpol = 0; tb_cpha = 0; tb_lsb = 0; loop_en = 1;
    avs_wr(ADDR_CTRL, 32'h0);
    avs_wr(ADDR_DIV, 32'h2);
    avs_wr(ADDR_TXDATA, 32'h3A);
    clr_mon();
    avs_wr(ADDR_SS, 32'h0);
    avs_wr(ADDR_CTRL, 32'hF);
    avs_wr(ADDR_TXDATA, 32'hFF);
    avs_wr(ADDR_DIV, 32'h7);
    avs_wr(ADDR_SS, 32'h1);
    wait_idle("busy_timeout");
    repeat (100) @(negedge clk);
    chk("busy_xfers", xfer_cnt, 32'd1);
    chk("busy_ss_low", low_cnt, 32'd54);
    chk("busy_ss1_low", low1_cnt, 32'd0);
    avs_rd(ADDR_STATUS, rd);
    chk("busy_status", rd, 32'h2);
    avs_rd(ADDR_RXDATA, rd);
    chk("busy_rx", rd, 32'h3A);
    avs_rd(ADDR_CTRL, rd);
    chk("busy_ctrl", rd, 32'h0);
    avs_rd(ADDR_TXDATA, rd);
    chk("busy_tx", rd, 32'h3A);
    avs_rd(ADDR_DIV, rd);
    chk("busy_div", rd, 32'h2);

    // read has priority over a simultaneous write
    @(negedge clk);
    avs_address = ADDR_TXDATA; avs_writedata = 32'h11;
    avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    chk("prio_rdata", avs_readdata, 32'h3A);
    avs_rd(ADDR_TXDATA, rd);
    chk("prio_tx_kept", rd, 32'h3A);

    // out-of-range slave index
    clr_mon();
    avs_wr(ADDR_SS, NS);
    chk("err_ss_n", {30'd0, ss_n}, 32'h3);
    avs_rd(ADDR_STATUS, rd);
    chk("err_status", rd, 32'h4);
    chk("err_no_xfer", xfer_cnt + low1_cnt, 32'd0);
    avs_wr(ADDR_STATUS, 32'h4);
    avs_rd(ADDR_STATUS, rd);
    chk("err_w1c", rd, 32'h0);

    // interrupt, DIV=0, slave 1
    avs_wr(ADDR_CTRL, 32'h8);
    avs_wr(ADDR_DIV, 32'h0);
    avs_wr(ADDR_TXDATA, 32'hC3);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    clr_mon();
    avs_wr(ADDR_SS, 32'h1);
    chk("irq_ss1", {30'd0, ss_n}, 32'h1);
    wait_idle("irq_timeout1");
    chk("div0_ss_low", low1_cnt, 32'd18);
    chk("irq_set", {31'd0, irq}, 32'd1);
    avs_rd(ADDR_RXDATA, rd);
    chk("div0_rx", rd, 32'hC3);
    chk("irq_rdclr", {31'd0, irq}, 32'd0);
    avs_wr(ADDR_SS, 32'h1);
    wait_idle("irq_timeout2");
    chk("irq_set2", {31'd0, irq}, 32'd1);
    avs_wr(ADDR_STATUS, 32'h2);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // asynchronous reset mid-SHIFT
    avs_wr(ADDR_CTRL, 32'h0);
    avs_wr(ADDR_DIV, 32'h3);
    avs_wr(ADDR_TXDATA, 32'hFF);
    avs_wr(ADDR_SS, 32'h0);
    repeat (17) @(negedge clk);
    chk("mid_sclk_high", {31'd0, sclk}, 32'd1);
    chk("mid_mosi", {31'd0, mosi}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sclk", {31'd0, sclk}, 32'd0);
    chk("arst_ss_n", {30'd0, ss_n}, 32'h3);
    chk("arst_mosi", {31'd0, mosi}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    avs_rd(ADDR_STATUS, rd);
    chk("arst_status", rd, 32'h0);
    avs_rd(ADDR_DIV, rd);
    chk("arst_div", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
